// File: rtl/ex_ctrl_pkg.sv
// Shared types and constants for the execute-stage forwarding/hazard controller.
package ex_ctrl_pkg;

  localparam int unsigned RA_W_DEF = 3;

  // ALU operand select encodings
  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_ALU = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  typedef enum logic {
    RUN,
    LU_STALL
  } fsm_t;

  // In-flight instruction record: valid, writes a reg, destination, is a load
  typedef struct packed {
    logic                v;
    logic                wr;
    logic [RA_W_DEF-1:0] dst;
    logic                ld;
  } stage_rec_t;

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding select: compares one source register against the
// EX and MEM producers; the younger (EX) producer takes priority.
module fwd_sel
  import ex_ctrl_pkg::*;
#(
  parameter int unsigned RA_W = RA_W_DEF
) (
  input  logic [RA_W-1:0] src,
  input  logic            use_src,
  input  stage_rec_t      ex_rec,
  input  logic            mem_v,
  input  logic            mem_wr,
  input  logic [RA_W-1:0] mem_dst,
  output logic [1:0]      sel,
  output logic            hit_any,
  output logic            hit_ex_ld
);

  logic hit_ex;
  logic hit_mem;

  // Match against producers and pick the youngest source of the value
  always_comb begin
    hit_ex    = use_src & ex_rec.v & ex_rec.wr & (ex_rec.dst == src);
    hit_mem   = use_src & mem_v & mem_wr & (mem_dst == src);
    sel       = SEL_RF;
    if (hit_ex)       sel = SEL_ALU;
    else if (hit_mem) sel = SEL_MEM;
    hit_any   = hit_ex | hit_mem;
    hit_ex_ld = hit_ex & ex_rec.ld;
  end

endmodule

// File: rtl/ex_forward_hazard_ctrl.sv
// Execute-stage sequencing: tracks EX/MEM destination registers, registers the
// operand-forwarding selects for the instruction entering EX, and stalls ID /
// injects an EX bubble on load-use (or on any RAW hazard when forwarding is off).
module ex_forward_hazard_ctrl
  import ex_ctrl_pkg::*;
#(
  parameter int unsigned RA_W   = RA_W_DEF,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_src1,
  input  logic [RA_W-1:0] id_src2,
  input  logic            id_use1,
  input  logic            id_use2,
  input  logic            id_wr_en,
  input  logic [RA_W-1:0] id_dst,
  input  logic            id_is_load,
  input  logic            mem_busy,
  input  logic            flush,
  output logic [1:0]      alu_src1,
  output logic [1:0]      alu_src2,
  output logic            ex_valid,
  output logic            stall_id
);

  stage_rec_t      ex_rec;
  logic            mem_v;
  logic            mem_wr;
  logic [RA_W-1:0] mem_dst;
  fsm_t            state;

  logic [1:0] sel1;
  logic [1:0] sel2;
  logic       hit_any1;
  logic       hit_any2;
  logic       ld1;
  logic       ld2;
  logic       use1;
  logic       use2;
  logic       load_use;
  logic       hazard;

  assign use1     = id_valid & id_use1;
  assign use2     = id_valid & id_use2;
  assign ex_valid = ex_rec.v;

  fwd_sel #(.RA_W(RA_W)) u_fwd_src1 (
    .src       (id_src1),
    .use_src   (use1),
    .ex_rec    (ex_rec),
    .mem_v     (mem_v),
    .mem_wr    (mem_wr),
    .mem_dst   (mem_dst),
    .sel       (sel1),
    .hit_any   (hit_any1),
    .hit_ex_ld (ld1)
  );

  fwd_sel #(.RA_W(RA_W)) u_fwd_src2 (
    .src       (id_src2),
    .use_src   (use2),
    .ex_rec    (ex_rec),
    .mem_v     (mem_v),
    .mem_wr    (mem_wr),
    .mem_dst   (mem_dst),
    .sel       (sel2),
    .hit_any   (hit_any2),
    .hit_ex_ld (ld2)
  );

  // Hazard detection and combinational ID stall
  always_comb begin
    // In LU_STALL the EX slot already holds the bubble, so no new load-use can arise
    load_use = (state == RUN) & (ld1 | ld2);
    hazard   = FWD_EN ? load_use : (hit_any1 | hit_any2);
    stall_id = mem_busy | (hazard & ~flush);
  end

  // Pipeline record tracker, registered selects and stall FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_rec   <= '0;
      mem_v    <= 1'b0;
      mem_wr   <= 1'b0;
      mem_dst  <= '0;
      alu_src1 <= SEL_RF;
      alu_src2 <= SEL_RF;
      state    <= RUN;
    end else if (mem_busy) begin
      // Tracker frozen; a redirect still kills the EX instruction in place
      if (flush) begin
        ex_rec.v <= 1'b0;
        alu_src1 <= SEL_RF;
        alu_src2 <= SEL_RF;
        state    <= RUN;
      end
    end else begin
      mem_v   <= ex_rec.v;
      mem_wr  <= ex_rec.wr;
      mem_dst <= ex_rec.dst;
      if (flush || hazard || !id_valid) begin
        ex_rec   <= '0;
        alu_src1 <= SEL_RF;
        alu_src2 <= SEL_RF;
      end else begin
        ex_rec   <= '{v: 1'b1, wr: id_wr_en, dst: id_dst, ld: id_is_load};
        alu_src1 <= FWD_EN ? sel1 : SEL_RF;
        alu_src2 <= FWD_EN ? sel2 : SEL_RF;
      end
      state <= (hazard && !flush) ? LU_STALL : RUN;
    end
  end

endmodule

// File: tb/tb_ex_forward_hazard_ctrl.sv
// Directed bench for ex_forward_hazard_ctrl: one instance with forwarding,
// one without, sharing the same ID-side stimulus.
module tb_ex_forward_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [2:0] id_src1;
  logic [2:0] id_src2;
  logic       id_use1;
  logic       id_use2;
  logic       id_wr_en;
  logic [2:0] id_dst;
  logic       id_is_load;
  logic       mem_busy;
  logic       flush;

  logic [1:0] src1, src2, nf_src1, nf_src2;
  logic       exv, stall, nf_exv, nf_stall;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ex_forward_hazard_ctrl #(.RA_W(3), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src1(id_src1),
    .id_src2(id_src2), .id_use1(id_use1), .id_use2(id_use2),
    .id_wr_en(id_wr_en), .id_dst(id_dst), .id_is_load(id_is_load),
    .mem_busy(mem_busy), .flush(flush), .alu_src1(src1), .alu_src2(src2),
    .ex_valid(exv), .stall_id(stall)
  );

  ex_forward_hazard_ctrl #(.RA_W(3), .FWD_EN(1'b0)) dut_nf (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src1(id_src1),
    .id_src2(id_src2), .id_use1(id_use1), .id_use2(id_use2),
    .id_wr_en(id_wr_en), .id_dst(id_dst), .id_is_load(id_is_load),
    .mem_busy(mem_busy), .flush(flush), .alu_src1(nf_src1), .alu_src2(nf_src2),
    .ex_valid(nf_exv), .stall_id(nf_stall)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [2:0] s1, input logic u1,
                        input logic [2:0] s2, input logic u2, input logic wr,
                        input logic [2:0] dst, input logic ld);
    id_valid = v; id_src1 = s1; id_use1 = u1; id_src2 = s2; id_use2 = u2;
    id_wr_en = wr; id_dst = dst; id_is_load = ld;
  endtask

  task automatic idle();
    set_id(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; mem_busy = 1'b0;
    // reset with a valid instruction sitting in ID
    set_id(1'b1, 3'd1, 1'b1, 3'd2, 1'b1, 1'b1, 3'd3, 1'b0);
    tick(); tick();
    check("rst_exv", exv, 0);
    check("rst_src1", src1, 0);
    check("rst_src2", src2, 0);
    rst_n = 1'b1; idle(); #1;
    check("rst_stall", stall, 0);
    tick();

    // ADD R1,R2,R3 ; ADD R2,R1,R3
    set_id(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b1, 3'd1, 1'b0); tick();
    check("t1_exv", exv, 1);
    set_id(1'b1, 3'd1, 1'b1, 3'd3, 1'b1, 1'b1, 3'd2, 1'b0); #1;
    check("t1_stall", stall, 0);
    tick();
    check("t1_src1", src1, 2'b01);
    check("t1_src2", src2, 2'b00);
    idle(); tick(); tick();

    // ADD R1 ; NOP ; SUB R4,R3,R1
    set_id(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b1, 3'd1, 1'b0); tick();
    idle(); tick();
    set_id(1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 1'b1, 3'd4, 1'b0); tick();
    check("t2_src1", src1, 2'b00);
    check("t2_src2", src2, 2'b10);
    idle(); tick(); tick();

    // ADD R1 ; ADD R1 ; ADD R7,R1,imm -> EX producer wins
    set_id(1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 1'b1, 3'd1, 1'b0); tick();
    set_id(1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 1'b1, 3'd1, 1'b0); tick();
    set_id(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 1'b1, 3'd7, 1'b0); tick();
    check("t3_src1", src1, 2'b01);
    check("t3_src2", src2, 2'b00);
    idle(); tick(); tick();

    // LDD R5 ; ADD R6,R5,R5 -> one-cycle load-use stall
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b1); tick();
    set_id(1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 1'b1, 3'd6, 1'b0); #1;
    check("t4_stall", stall, 1);
    tick();
    check("t4_bubble", exv, 0);
    check("t4_stall_rel", stall, 0);
    tick();
    check("t4_exv", exv, 1);
    check("t4_src1", src1, 2'b10);
    check("t4_src2", src2, 2'b10);
    idle(); tick(); tick();

    // load-use coinciding with flush
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b1); tick();
    set_id(1'b1, 3'd5, 1'b1, 3'd5, 1'b1, 1'b1, 3'd6, 1'b0); flush = 1'b1; #1;
    check("t5_stall", stall, 0);
    tick();
    flush = 1'b0;
    check("t5_bubble", exv, 0);
    #1;
    check("t5_stall_after", stall, 0);
    tick();
    check("t5_src1", src1, 2'b10);
    idle(); tick(); tick();

    // mem_busy freeze for 3 cycles
    set_id(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b1, 3'd1, 1'b0); tick();
    set_id(1'b1, 3'd1, 1'b1, 3'd3, 1'b1, 1'b1, 3'd2, 1'b0); tick();
    check("t6_pre_src1", src1, 2'b01);
    mem_busy = 1'b1;
    set_id(1'b1, 3'd2, 1'b1, 3'd2, 1'b1, 1'b1, 3'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t6_busy_stall", stall, 1);
      tick();
      check("t6_busy_exv", exv, 1);
      check("t6_busy_src1", src1, 2'b01);
      check("t6_busy_src2", src2, 2'b00);
    end
    mem_busy = 1'b0; #1;
    check("t6_resume_stall", stall, 0);
    tick();
    check("t6_resume_src1", src1, 2'b01);
    check("t6_resume_src2", src2, 2'b01);
    idle(); tick(); tick();

    // non-writing producer and self-referencing instruction
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd1, 1'b0); tick();
    set_id(1'b1, 3'd1, 1'b1, 3'd1, 1'b1, 1'b1, 3'd2, 1'b0); tick();
    check("t7_nowr_src1", src1, 2'b00);
    check("t7_nowr_src2", src2, 2'b00);
    idle(); tick(); tick();
    set_id(1'b1, 3'd4, 1'b1, 3'd4, 1'b1, 1'b1, 3'd4, 1'b0); #1;
    check("t7_self_stall", stall, 0);
    tick();
    check("t7_self_src1", src1, 2'b00);
    idle(); tick(); tick();

    // reset during a load-use stall
    set_id(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b1); tick();
    set_id(1'b1, 3'd5, 1'b1, 3'd0, 1'b0, 1'b1, 3'd6, 1'b0); #1;
    check("t9_stall", stall, 1);
    rst_n = 1'b0; tick();
    rst_n = 1'b1;
    check("t9_rst_exv", exv, 0);
    check("t9_rst_stall", stall, 0);
    idle(); tick();

    // forwarding disabled: ADD R1 ; ADD R2,R1,R3 -> two stall cycles
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    set_id(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 1'b1, 3'd1, 1'b0); tick();
    set_id(1'b1, 3'd1, 1'b1, 3'd3, 1'b1, 1'b1, 3'd2, 1'b0); #1;
    check("nf_stall1", nf_stall, 1);
    tick();
    check("nf_bubble1", nf_exv, 0);
    check("nf_src1_b", nf_src1, 2'b00);
    check("nf_stall2", nf_stall, 1);
    tick();
    check("nf_bubble2", nf_exv, 0);
    check("nf_stall3", nf_stall, 0);
    tick();
    check("nf_exv", nf_exv, 1);
    check("nf_src1", nf_src1, 2'b00);
    check("nf_src2", nf_src2, 2'b00);
    idle(); tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
